pc_call_unit: RTL and testbench

- Program counter for the 16-bit CPU datapath; drives the instruction-memory address.
- Sits directly downstream of the 16-bit load register: load data arrives on `in`, and it adds increment, jump, clear and call/return.
- Contains a hardware return-address LIFO of DEPTH entries, with full/empty status and sticky overflow/underflow error flags.

---
 rtl/pc_pkg.sv | 50 +++++
 rtl/pc_ret_stack.sv | 92 +++++++++
 rtl/pc_call_unit.sv | 108 ++++++++++
 tb/tb_pc_call_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared defaults and the operation decoder for the program
//                counter / call unit.
//                  PC_WIDTH        - default PC and return-address width
//                  PC_DEPTH        - default return-stack depth
//                  PC_RESET_VECTOR - default PC value after reset or clear
//                  pc_op_e         - one operation per edge, already resolved
//                                    by priority
//                  pc_decode()     - fixed-priority control decoder
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int unsigned PC_WIDTH        = 16;
    localparam int unsigned PC_DEPTH        = 8;
    localparam int unsigned PC_RESET_VECTOR = 0;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_INC   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_CLEAR = 3'd5
    } pc_op_e;

    // Priority: clear > ret > call > load > inc > hold.
    // Lower-priority requests on the same edge are dropped here, so nothing
    // downstream ever sees more than one operation at a time.
    function automatic pc_op_e pc_decode(
        input logic clr_req,
        input logic ret_req,
        input logic call_req,
        input logic load_req,
        input logic inc_req
    );
        pc_op_e op;
        if (clr_req)       op = OP_CLEAR;
        else if (ret_req)  op = OP_RET;
        else if (call_req) op = OP_CALL;
        else if (load_req) op = OP_LOAD;
        else if (inc_req)  op = OP_INC;
        else               op = OP_HOLD;
        return op;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ret_stack
//  Description : Return-address LIFO with push/pop/clear, an occupancy count,
//                full/empty status and top-of-stack read.
//                Requests that cannot be honoured (push when full, pop when
//                empty) leave the stack unchanged and are reported on
//                push_rejected / pop_rejected in the same cycle.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                clear             - empty the stack (highest priority)
//                push, push_data   - push request and data
//                pop               - pop request (wins over push)
//                top_data          - entry at depth-1 (don't-care when empty)
//                depth             - number of valid entries
//                full, empty       - occupancy status
//                push_rejected     - push requested while full
//                pop_rejected      - pop requested while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ret_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top_data,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     push_rejected,
    output logic                     pop_rejected
);

    localparam int unsigned c_ADDR_W  = $clog2(DEPTH);
    localparam int unsigned c_DEPTH_W = c_ADDR_W + 1;

    logic [c_DEPTH_W-1:0] r_depth;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_do_push;
    logic                 w_do_pop;
    logic [c_ADDR_W-1:0]  w_wr_idx;
    logic [c_ADDR_W-1:0]  w_rd_idx;

    assign w_full  = (r_depth == c_DEPTH_W'(DEPTH));
    assign w_empty = (r_depth == '0);

    // Pop outranks push; clear outranks both.
    assign w_do_pop      = pop  & ~clear & ~w_empty;
    assign w_do_push     = push & ~clear & ~pop & ~w_full;
    assign pop_rejected  = pop  & ~clear & w_empty;
    assign push_rejected = push & ~clear & ~pop & w_full;

    // Depth is a power of two, so the low address bits of the count are the
    // next free slot, and (count-1) in the same width is the top slot. When
    // full the low bits are zero and the subtraction wraps to DEPTH-1.
    assign w_wr_idx = r_depth[c_ADDR_W-1:0];
    assign w_rd_idx = r_depth[c_ADDR_W-1:0] - c_ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (clear) begin
            r_depth <= '0;
        end else if (w_do_pop) begin
            r_depth <= r_depth - c_DEPTH_W'(1);
        end else if (w_do_push) begin
            r_depth <= r_depth + c_DEPTH_W'(1);
        end
    end

    // Storage is intentionally left unreset; entries above depth are never
    // observed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign top_data = r_mem[w_rd_idx];
    assign depth    = r_depth;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule : pc_ret_stack
`default_nettype wire

// File: rtl/pc_call_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_call_unit
//  Description : Program counter with increment, jump, synchronous clear and
//                call/return through a hardware return-address stack.
//                Exactly one operation per edge, by fixed priority
//                clear > ret > call > load > inc > hold.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                in                - jump / call target
//                clear, load, inc  - clear, jump, increment requests
//                call, ret         - call / return requests
//                out               - current PC (registered)
//                depth             - valid return-stack entries
//                stack_full/empty  - return-stack status
//                overflow_err      - sticky: call attempted while full
//                underflow_err     - sticky: ret attempted while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_call_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = PC_WIDTH,
    parameter int unsigned     DEPTH        = PC_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   inc,
    input  logic                   call,
    input  logic                   ret,
    output logic [WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    pc_op_e           w_op;
    logic [WIDTH-1:0] w_pc_plus1;
    logic [WIDTH-1:0] w_top;
    logic             w_push_rej;
    logic             w_pop_rej;

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_unf;

    assign w_op       = pc_decode(clear, ret, call, load, inc);
    // Serves both inc and the return address; wraps naturally at 2^WIDTH.
    assign w_pc_plus1 = r_pc + WIDTH'(1);

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (w_op == OP_CLEAR),
        .push          (w_op == OP_CALL),
        .pop           (w_op == OP_RET),
        .push_data     (w_pc_plus1),
        .top_data      (w_top),
        .depth         (depth),
        .full          (stack_full),
        .empty         (stack_empty),
        .push_rejected (w_push_rej),
        .pop_rejected  (w_pop_rej)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_VECTOR;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            case (w_op)
                OP_CLEAR: begin
                    r_pc  <= RESET_VECTOR;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
                OP_RET: begin
                    if (w_pop_rej) r_unf <= 1'b1;
                    else           r_pc  <= w_top;
                end
                OP_CALL: begin
                    // A rejected push also suppresses the jump so the
                    // program does not lose its way back.
                    if (w_push_rej) r_ovf <= 1'b1;
                    else            r_pc  <= in;
                end
                OP_LOAD: r_pc <= in;
                OP_INC:  r_pc <= w_pc_plus1;
                default: ;
            endcase
        end
    end

    assign out           = r_pc;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule : pc_call_unit
`default_nettype wire

// File: tb/tb_pc_call_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_call_unit
//  Description : Self-checking bench for pc_call_unit. A behavioural model
//                predicts the visible state for every driven cycle and queues
//                it; each scenario task pops and compares after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_call_unit;

    localparam logic [4:0] c_NOP  = 5'b00000;
    localparam logic [4:0] c_INC  = 5'b00001;
    localparam logic [4:0] c_LD   = 5'b00010;
    localparam logic [4:0] c_CALL = 5'b00100;
    localparam logic [4:0] c_RET  = 5'b01000;
    localparam logic [4:0] c_CLR  = 5'b10000;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  dep;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din   = '0;
    logic        clear = 1'b0;
    logic        load  = 1'b0;
    logic        inc   = 1'b0;
    logic        call  = 1'b0;
    logic        ret   = 1'b0;
    logic [15:0] out;
    logic [3:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow_err;
    logic        underflow_err;

    obs_t        sb[$];
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    int total = 0;
    int bad   = 0;

    pc_call_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in            (din),
        .clear         (clear),
        .load          (load),
        .inc           (inc),
        .call          (call),
        .ret           (ret),
        .out           (out),
        .depth         (depth),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_state();
        obs_t s;
        s.pc    = m_pc;
        s.dep   = 4'(m_stk.size());
        s.full  = (m_stk.size() == 8);
        s.empty = (m_stk.size() == 0);
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.pc    = out;
        s.dep   = depth;
        s.full  = stack_full;
        s.empty = stack_empty;
        s.ovf   = overflow_err;
        s.unf   = underflow_err;
        return s;
    endfunction

    function automatic string fmt(input obs_t s);
        return $sformatf("out=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                         s.pc, s.dep, s.full, s.empty, s.ovf, s.unf);
    endfunction

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model, queue its prediction.
    task automatic drive(input logic [4:0] ops, input logic [15:0] d);
        {clear, ret, call, load, inc} = ops;
        din = d;
        if (ops[4]) begin
            model_reset();
        end else if (ops[3]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_unf = 1'b1;
        end else if (ops[2]) begin
            if (m_stk.size() < 8) begin
                m_stk.push_back(m_pc + 16'h0001);
                m_pc = d;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (ops[1]) begin
            m_pc = d;
        end else if (ops[0]) begin
            m_pc = m_pc + 16'h0001;
        end
        @(posedge clk);
        #1;
        {clear, ret, call, load, inc} = 5'b0;
        sb.push_back(model_state());
    endtask

    task automatic test_reset();
        obs_t o, e;
        model_reset();
        sb.push_back(model_state());
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_initial: got %s exp %s", fmt(o), fmt(e)); end

        drive(c_LD, 16'h0042);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_preload: got %s exp %s", fmt(o), fmt(e)); end

        // Assert reset between edges; outputs must respond without a clock.
        #2 rst_n = 1'b0;
        model_reset();
        sb.push_back(model_state());
        #1;
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_async: got %s exp %s", fmt(o), fmt(e)); end
        #3 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            drive(c_INC, 16'h0000);
            o = sample(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_inc%0d: got %s exp %s", k, fmt(o), fmt(e)); end
        end
        total++;
        if (out !== 16'h0003) begin bad++; $display("FAIL reset_inc_final: got out=%h exp out=0003", out); end
    endtask

    task automatic test_jump_inc();
        obs_t o, e;
        logic [4:0]  ops [7] = '{c_LD, c_LD | c_INC, c_LD, c_INC, c_LD, c_CALL, c_RET};
        logic [15:0] dat [7] = '{16'h0005, 16'h1234, 16'hFFFF, 16'h0000,
                                 16'hFFFF, 16'h0040, 16'h0000};
        for (int k = 0; k < 7; k++) begin
            drive(ops[k], dat[k]);
            o = sample(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL jump_inc step%0d: got %s exp %s", k, fmt(o), fmt(e)); end
            if (k == 1) begin
                total++;
                if (out !== 16'h1234) begin bad++; $display("FAIL load_over_inc: got out=%h exp out=1234", out); end
            end
        end
        // Hold: nothing asserted, nothing moves.
        drive(c_NOP, 16'hAAAA);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL hold: got %s exp %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_call_ret();
        obs_t o, e;
        logic [4:0]  ops [5] = '{c_LD, c_CALL, c_CALL, c_RET, c_RET};
        logic [15:0] dat [5] = '{16'h0010, 16'h0100, 16'h0200, 16'h0000, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            drive(ops[k], dat[k]);
            o = sample(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL call_ret step%0d: got %s exp %s", k, fmt(o), fmt(e)); end
        end
        total++;
        if (out !== 16'h0011 || stack_empty !== 1'b1) begin
            bad++; $display("FAIL call_ret_final: got out=%h empty=%b exp out=0011 empty=1", out, stack_empty);
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        for (int k = 0; k < 8; k++) begin
            drive(c_CALL, 16'h1000 + 16'(k));
            o = sample(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL ovf_call%0d: got %s exp %s", k, fmt(o), fmt(e)); end
        end
        drive(c_CALL, 16'hBEEF);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL ovf_9th: got %s exp %s", fmt(o), fmt(e)); end
        total++;
        if (out !== 16'h1007 || depth !== 4'd8 || overflow_err !== 1'b1) begin
            bad++; $display("FAIL ovf_9th_const: got out=%h depth=%0d ovf=%b exp out=1007 depth=8 ovf=1",
                            out, depth, overflow_err);
        end
        drive(c_RET, 16'h0000);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL ovf_sticky: got %s exp %s", fmt(o), fmt(e)); end
        drive(c_CLR, 16'h0000);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL ovf_clear: got %s exp %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_underflow_clear();
        obs_t o, e;
        drive(c_LD, 16'h0777);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL unf_setup: got %s exp %s", fmt(o), fmt(e)); end
        drive(c_RET, 16'h0000);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL unf_ret: got %s exp %s", fmt(o), fmt(e)); end
        total++;
        if (out !== 16'h0777 || underflow_err !== 1'b1) begin
            bad++; $display("FAIL unf_const: got out=%h unf=%b exp out=0777 unf=1", out, underflow_err);
        end
        drive(c_CLR | c_RET, 16'h0000);
        o = sample(); e = sb.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL clear_over_ret: got %s exp %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [4:0]  ops [5] = '{c_LD, c_CALL, c_CALL, c_RET | c_CALL, c_RET | c_LD | c_INC};
        logic [15:0] dat [5] = '{16'h0050, 16'h0060, 16'h0070, 16'h0300, 16'h0999};
        for (int k = 0; k < 5; k++) begin
            drive(ops[k], dat[k]);
            o = sample(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b step%0d: got %s exp %s", k, fmt(o), fmt(e)); end
            if (k == 3) begin
                total++;
                if (out !== 16'h0061 || depth !== 4'd1) begin
                    bad++; $display("FAIL ret_over_call: got out=%h depth=%0d exp out=0061 depth=1", out, depth);
                end
            end
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        test_reset();
        test_jump_inc();
        test_call_ret();
        test_overflow();
        test_underflow_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_call_unit
`default_nettype wire
